// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers.
// MULT/MULTU/DIV/DIVU latch their operands at issue, hold busy for a fixed
// number of cycles and write {HI,LO} at completion. MTHI/MTLO write in one
// edge, and MFHI/MFLO read through the combinational res port.
module mul_div_unit #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] res
);

    typedef enum logic [3:0] {
        OP_NONE  = 4'b0000,
        OP_MULT  = 4'b0001,
        OP_MULTU = 4'b0010,
        OP_DIV   = 4'b0011,
        OP_DIVU  = 4'b0100,
        OP_MTHI  = 4'b0101,
        OP_MTLO  = 4'b0110,
        OP_MFHI  = 4'b0111,
        OP_MFLO  = 4'b1000
    } md_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } state_e;

    localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = (MAX_CYC < 1) ? 1 : $clog2(MAX_CYC + 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [31:0]        a_q,     a_d;
    logic [31:0]        b_q,     b_d;
    md_op_e             op_q,    op_d;
    logic [31:0]        hi_q,    hi_d;
    logic [31:0]        lo_q,    lo_d;

    md_op_e             op_in;
    assign op_in = md_op_e'(md_op);

    // Multiply datapath: sign- or zero-extend both operands to 64 bits; the
    // low 64 bits of the 64x64 product are then correct for either signedness.
    logic        mul_signed;
    logic [63:0] a_ext, b_ext, product;
    assign mul_signed = (op_q == OP_MULT);
    assign a_ext      = {{32{mul_signed & a_q[31]}}, a_q};
    assign b_ext      = {{32{mul_signed & b_q[31]}}, b_q};
    assign product    = a_ext * b_ext;

    // Divide datapath in sign-magnitude form. Truncation toward zero falls out
    // of dividing magnitudes; the remainder takes the dividend's sign.
    // 0x80000000 / -1 needs no special case: |0x80000000| is itself, and a
    // positive quotient of 0x80000000 is the required wrap-around value.
    logic        div_signed, a_neg, b_neg;
    logic [31:0] a_mag, b_mag, q_mag, r_mag, quotient, remainder;
    assign div_signed = (op_q == OP_DIV);
    assign a_neg      = div_signed & a_q[31];
    assign b_neg      = div_signed & b_q[31];
    assign a_mag      = a_neg ? -a_q : a_q;
    assign b_mag      = b_neg ? -b_q : b_q;
    assign q_mag      = a_mag / b_mag;
    assign r_mag      = a_mag % b_mag;
    assign quotient   = (a_neg ^ b_neg) ? -q_mag : q_mag;
    assign remainder  = a_neg ? -r_mag : r_mag;

    // Next-state logic: issue from IDLE, count down in MUL/DIV, write at the end.
    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path
        // through the case statement can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    unique case (op_in)
                        OP_MULT, OP_MULTU: begin
                            a_d     = A;
                            b_d     = B;
                            op_d    = op_in;
                            cnt_d   = CNT_W'(MUL_CYCLES);
                            state_d = S_MUL;
                        end
                        OP_DIV, OP_DIVU: begin
                            a_d     = A;
                            b_d     = B;
                            op_d    = op_in;
                            cnt_d   = CNT_W'(DIV_CYCLES);
                            state_d = S_DIV;
                        end
                        OP_MTHI: hi_d = A;
                        OP_MTLO: lo_d = A;
                        default: ; // NONE, MFHI, MFLO and unused codes change no state
                    endcase
                end
            end
            S_MUL: begin
                if (cnt_q <= CNT_W'(1)) begin
                    {hi_d, lo_d} = product;
                    cnt_d        = '0;
                    state_d      = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DIV: begin
                if (cnt_q <= CNT_W'(1)) begin
                    // A zero divisor still spends the full latency but leaves HI/LO alone.
                    if (b_q != '0) begin
                        hi_d = remainder;
                        lo_d = quotient;
                    end
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State register with synchronous active-low reset; reset wins over start.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples the pre-edge values.
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= OP_NONE;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign hi   = hi_q;
    assign lo   = lo_q;
    assign res  = (op_in == OP_MFHI) ? hi_q :
                  (op_in == OP_MFLO) ? lo_q : 32'h0;

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 The block SHALL have parameter MUL_CYCLES, default 5: busy cycles for MULT/MULTU.
REQ-002 The block SHALL have parameter DIV_CYCLES, default 10: busy cycles for DIV/DIVU.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-low reset; reset==0 at a rising edge resets the block.
REQ-005 The block SHALL have port start, input, 1 bit: issue strobe for the operation on md_op (E stage).
REQ-006 The block SHALL have port md_op, input, 4 bits, with these codes: NONE 0000, MULT 0001, MULTU 0010, DIV 0011, DIVU 0100, MTHI 0101, MTLO 0110, MFHI 0111, MFLO 1000.
REQ-007 The block SHALL have port A, input, 32 bits: rs operand (dividend / multiplicand / MTHI/MTLO source).
REQ-008 The block SHALL have port B, input, 32 bits: rt operand (divisor / multiplier).
REQ-009 The block SHALL have port busy, output, 1 bit: a multi-cycle operation is in progress.
REQ-010 The block SHALL have port hi, output, 32 bits: the HI register.
REQ-011 The block SHALL have port lo, output, 32 bits: the LO register.
REQ-012 The block SHALL have port res, output, 32 bits: combinational read result for MFHI/MFLO.

Function
REQ-013 The block SHALL implement a three-state FSM: IDLE, MUL, DIV.
REQ-014 In IDLE, start=1 with MULT/MULTU SHALL latch A, B and op, load the counter with MUL_CYCLES, and go to MUL.
REQ-015 In IDLE, start=1 with DIV/DIVU SHALL do the same with DIV_CYCLES and go to DIV.
REQ-016 busy SHALL be 1 exactly while state is MUL or DIV: N cycles for N-cycle ops, starting the cycle after the start edge.
REQ-017 The counter SHALL decrement each cycle in MUL/DIV; at the edge where it reaches 1, HI/LO SHALL be written, the state SHALL return to IDLE, and busy SHALL fall.
REQ-018 MULT SHALL compute the signed 64-bit product of A and B, and MULTU the unsigned one; {HI,LO} SHALL receive the product.
REQ-019 DIV SHALL be signed, truncating toward zero: LO=quotient, HI=remainder with the dividend's sign; DIVU SHALL be unsigned.
REQ-020 DIV with 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000 and HI=0.
REQ-021 A divisor of 0 SHALL still take DIV_CYCLES busy cycles and SHALL leave HI and LO unchanged.
REQ-022 Results SHALL depend only on operands latched at start; A/B changes during busy SHALL have no effect.
REQ-023 start=1 with MTHI/MTLO in IDLE SHALL write A into HI/LO at that edge, with no busy.
REQ-024 res SHALL equal hi when md_op=MFHI, lo when md_op=MFLO, and 0 otherwise, regardless of start or busy.
REQ-025 start=1 while busy SHALL be ignored for every op, including MTHI/MTLO; the pipeline is responsible for stalling.
REQ-026 start=1 with NONE or MFHI/MFLO SHALL change no state.
REQ-027 Arithmetic results SHALL be written to HI/LO only at completion; hi/lo SHALL show the old values throughout busy.

Reset
REQ-028 reset==0 at a rising edge SHALL force state=IDLE, counter=0, busy=0, HI=0, LO=0, and clear the latched operands.
REQ-029 Reset during MUL/DIV SHALL abort the operation and discard its result; busy SHALL be 0 in the cycle after the reset edge.
REQ-030 Reset SHALL take priority over start at the same edge.

Verification
REQ-031 The bench SHALL cover MULT with A=0xFFFFFFFE, B=3: busy high for exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-032 The bench SHALL cover MULTU with A=0xFFFFFFFE, B=3: HI=0x00000002, LO=0xFFFFFFFA after 5 busy cycles.
REQ-033 The bench SHALL cover DIV with A=0xFFFFFFF9 (-7), B=2: 10 busy cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; and DIVU with A=7, B=2: LO=3, HI=1.
REQ-034 The bench SHALL cover MTHI A=0x12345678, then DIV by B=0: 10 busy cycles, HI stays 0x12345678, LO stays 0; MFHI gives res=0x12345678.
REQ-035 The bench SHALL cover MULT started, then start=1 with MTLO A=0xDEADBEEF at busy cycle 2: it is ignored, and LO equals the product at completion.
REQ-036 The bench SHALL cover DIV started, then reset=0 at busy cycle 4: the next cycle shows busy=0, HI=LO=0, and no later write occurs.
